// File: rtl/split_pipelined_subtractor_pkg.sv
// Shared widths and record types for the split pipelined subtractor.
// The default datapath width lives here so the top and its users agree on it.
package split_sub_pkg;

  localparam int SUB_W    = 32;
  localparam int SUB_LO_W = SUB_W / 2;
  localparam int SUB_HI_W = SUB_W - SUB_LO_W;

  typedef logic [SUB_W-1:0]    w_t;
  typedef logic [SUB_LO_W-1:0] lo_t;
  typedef logic [SUB_HI_W-1:0] hi_t;

  typedef struct packed {
    lo_t  diff;
    logic borrow;
    hi_t  a_hi;
    hi_t  b_hi;
  } s0_t;

  typedef struct packed {
    logic bout;
    w_t   y;
  } result_t;

endpackage

// File: rtl/split_pipelined_subtractor_sub_slice.sv
// Combinational N-bit subtractor with borrow-in and borrow-out.
// The extra top bit of the widened difference is the borrow-out.
module sub_slice #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_bin,
  output logic [N-1:0] o_d,
  output logic         o_bout
);

  logic [N:0] w_full;

  assign w_full         = {1'b0, i_a} - {1'b0, i_b} - {{N{1'b0}}, i_bin};
  assign {o_bout, o_d}  = w_full;

endmodule

// File: rtl/split_pipelined_subtractor.sv
// Two-stage W-bit subtractor: low half plus its borrow in stage 0, high half in stage 1.
// Handshake: a side transfers on vld & rdy; in_rdy is combinational from out_rdy.
module split_pipelined_subtractor
  import split_sub_pkg::*;
#(
  parameter int W = SUB_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_bin,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_y,
  output logic         out_bout
);

  localparam int LO_W = W / 2;
  localparam int HI_W = W - LO_W;

  if (((W % 2) != 0) || (W < 2)) begin : g_bad_width
    $error("split_pipelined_subtractor: W must be even and at least 2");
  end

  logic            r_s0_vld;
  logic [LO_W-1:0] r_s0_diff;
  logic            r_s0_borrow;
  logic [HI_W-1:0] r_s0_a_hi;
  logic [HI_W-1:0] r_s0_b_hi;
  logic            r_s1_vld;
  logic [W-1:0]    r_y;
  logic            r_bout;

  logic            w_en0;
  logic            w_en1;
  logic [LO_W-1:0] w_lo_diff;
  logic            w_lo_borrow;
  logic [HI_W-1:0] w_hi_diff;
  logic            w_hi_borrow;

  assign w_en1  = !r_s1_vld || out_rdy;
  assign w_en0  = !r_s0_vld || w_en1;
  assign in_rdy = w_en0;

  sub_slice #(.N(LO_W)) u_lo (
    .i_a    (in_a[LO_W-1:0]),
    .i_b    (in_b[LO_W-1:0]),
    .i_bin  (in_bin),
    .o_d    (w_lo_diff),
    .o_bout (w_lo_borrow)
  );

  // High half consumes the registered low-half borrow, breaking the carry chain.
  sub_slice #(.N(HI_W)) u_hi (
    .i_a    (r_s0_a_hi),
    .i_b    (r_s0_b_hi),
    .i_bin  (r_s0_borrow),
    .o_d    (w_hi_diff),
    .o_bout (w_hi_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_vld    <= 1'b0;
      r_s0_diff   <= '0;
      r_s0_borrow <= 1'b0;
      r_s0_a_hi   <= '0;
      r_s0_b_hi   <= '0;
    end else if (w_en0) begin
      r_s0_vld <= in_vld;
      if (in_vld) begin
        r_s0_diff   <= w_lo_diff;
        r_s0_borrow <= w_lo_borrow;
        r_s0_a_hi   <= in_a[W-1:LO_W];
        r_s0_b_hi   <= in_b[W-1:LO_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_y      <= '0;
      r_bout   <= 1'b0;
    end else if (w_en1) begin
      r_s1_vld <= r_s0_vld;
      if (r_s0_vld) begin
        r_y    <= {w_hi_diff, r_s0_diff};
        r_bout <= w_hi_borrow;
      end
    end
  end

  assign out_vld  = r_s1_vld;
  assign out_y    = r_y;
  assign out_bout = r_bout;

endmodule

// File: tb/tb_split_pipelined_subtractor.sv
// Bench for split_pipelined_subtractor: directed literal cases, backpressure,
// mid-flight reset and a randomized stream scored against an arithmetic model.
module tb_split_pipelined_subtractor;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_bin;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] out_y;
  logic         out_bout;

  split_pipelined_subtractor #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_bin   (in_bin),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_y    (out_y),
    .out_bout (out_bout)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int           n_vec = 0;
  int           n_err = 0;
  logic [W:0]   exp_q[$];
  logic         prev_stall = 1'b0;
  logic [W:0]   prev_out   = '0;
  logic         in_xfer    = 1'b0;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {bout, y} as one W+1 bit unsigned difference.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic bin);
    return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h0000_FFFF;
      3:       return 32'h0001_0000;
      default: return $urandom;
    endcase
  endfunction

  // Queue length at the falling edge equals the number of items inside the pipe.
  always @(negedge clk) begin
    in_xfer = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", {{W{1'b0}}, out_vld}, 1);
        check("hold_data", {out_bout, out_y}, prev_out);
      end
      check("in_rdy", {{W{1'b0}}, in_rdy}, {{W{1'b0}}, !(exp_q.size() == 2 && !out_rdy)});
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got 0x%0h, expected no result at %0t",
                   {out_bout, out_y}, $time);
        end else begin
          check("result", {out_bout, out_y}, exp_q.pop_front());
        end
      end
      if (in_vld && in_rdy) begin
        exp_q.push_back(model(in_a, in_b, in_bin));
        in_xfer = 1'b1;
      end
      prev_stall = out_vld && !out_rdy;
      prev_out   = {out_bout, out_y};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W:0] exp, input string name);
    @(posedge clk);
    #1;
    in_vld  = 1'b1;
    in_a    = a;
    in_b    = b;
    in_bin  = bin;
    out_rdy = 1'b1;
    @(negedge clk);
    check({name, "_in_rdy"}, {{W{1'b0}}, in_rdy}, 1);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    @(negedge clk);
    check({name, "_lat1"}, {{W{1'b0}}, out_vld}, 0);
    @(negedge clk);
    check({name, "_lat2"}, {{W{1'b0}}, out_vld}, 1);
    check(name, {out_bout, out_y}, exp);
  endtask

  task automatic backpressure();
    int         idx = 0;
    logic [W-1:0] got[$];
    logic       saw_full = 1'b0;
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      @(posedge clk);
      #1;
      out_rdy = !(cyc >= 2 && cyc <= 4);
      in_vld  = (idx < 4);
      in_a    = W'(10 + idx);
      in_b    = 1;
      in_bin  = 1'b0;
      @(negedge clk);
      if (!in_rdy) saw_full = 1'b1;
      if (out_vld && out_rdy) got.push_back(out_y);
      if (in_vld && in_rdy) idx++;
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    check("bp_full", {{W{1'b0}}, saw_full}, 1);
    check("bp_count", (W+1)'(got.size()), 4);
    for (int i = 0; i < 4; i++)
      check("bp_order", (i < got.size()) ? {1'b0, got[i]} : 'x, (W+1)'(9 + i));
  endtask

  task automatic reset_mid_flight();
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_a    = 100;
    in_b    = 7;
    in_bin  = 1'b0;
    @(posedge clk);
    #1;
    in_a = 200;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    #1;
    check("mf_full_vld", {{W{1'b0}}, out_vld}, 1);
    check("mf_full_rdy", {{W{1'b0}}, in_rdy}, 0);
    rst_n = 1'b0;
    #1;
    check("mf_rst_vld", {{W{1'b0}}, out_vld}, 0);
    check("mf_rst_out", {out_bout, out_y}, 0);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mf_no_stale", {{W{1'b0}}, out_vld}, 0);
      check("mf_in_rdy", {{W{1'b0}}, in_rdy}, 1);
    end
  endtask

  task automatic random_stream(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (!in_vld || in_xfer) begin
        in_vld = ($urandom_range(0, 3) != 0);
        in_a   = rnd_operand();
        in_b   = ($urandom_range(0, 7) == 0) ? in_a : rnd_operand();
        in_bin = 1'($urandom_range(0, 1));
      end
      out_rdy = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    repeat (4) @(negedge clk);
    check("drain_empty", (W+1)'(exp_q.size()), 0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_a    = '0;
    in_b    = '0;
    in_bin  = 1'b0;
    out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_vld", {{W{1'b0}}, out_vld}, 0);
    check("rst_out", {out_bout, out_y}, 0);
    check("rst_in_rdy", {{W{1'b0}}, in_rdy}, 1);

    directed(32'd5, 32'd3, 1'b0, 33'h0_0000_0002, "basic");
    directed(32'd0, 32'd1, 1'b0, 33'h1_FFFF_FFFF, "underflow");
    directed(32'h0001_0000, 32'h0000_0001, 1'b0, 33'h0_0000_FFFF, "cross_half");
    directed(32'h8000_0000, 32'h8000_0000, 1'b1, 33'h1_FFFF_FFFF, "equal_bin");
    directed(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h0_FFFF_FFFE, "max_bin");
    directed(32'h0000_0000, 32'h0000_FFFF, 1'b1, 33'h1_FFFF_0000, "lo_bin_chain");

    backpressure();
    reset_mid_flight();
    random_stream(10000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/split_pipelined_subtractor.md
Name: split_pipelined_subtractor

Overview:
- Two-stage pipelined W-bit subtractor with borrow-in and borrow-out: y = a - b - bin.
- Splits the operands into low and high halves; the borrow between the halves is registered between stages to shorten the critical path.
- Uses a valid/ready handshake on both sides with full backpressure.
- Sits beside the registered adder in the arithmetic datapath library as the subtract counterpart for wide counters and pointer arithmetic.

Parameters:
- W, 32, operand and result width in bits; must be even and at least 2. An elaboration-time assertion fails otherwise.
- LO_W, W/2, derived width of the low half; not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_vld  input  1  input operands valid.
- in_rdy  output  1  block can accept input this cycle.
- in_a  input  W  minuend, unsigned.
- in_b  input  W  subtrahend, unsigned.
- in_bin  input  1  borrow-in.
- out_vld  output  1  result valid.
- out_rdy  input  1  downstream accepts the result this cycle.
- out_y  output  W  difference, (in_a - in_b - in_bin) mod 2^W.
- out_bout  output  1  borrow-out; 1 iff in_a < in_b + in_bin, unsigned.

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous assert, active-low. Deassertion is synchronised externally.
- Reset values:
  - s0_vld = 0, s1_vld = 0.
  - out_vld = 0, out_y = 0, out_bout = 0.
  - in_rdy = 1 in the first cycle after deassertion.
- Stage 0, captured on an input transfer (in_vld & in_rdy):
  - lo_diff = a[LO_W-1:0] - b[LO_W-1:0] - bin.
  - lo_borrow = 1 iff a_lo < b_lo + bin.
  - Registers a[W-1:LO_W] and b[W-1:LO_W] unchanged.
  - Sets s0_vld.
- Stage 1, captured on advance:
  - hi_diff = a_hi - b_hi - lo_borrow.
  - out_bout = borrow of that operation.
  - out_y = {hi_diff, lo_diff}.
  - Sets s1_vld.
- Outputs: out_vld = s1_vld. out_y and out_bout come directly from stage-1 registers; no combinational path from inputs to outputs.
- Latency and throughput:
  - Latency is exactly 2 cycles from input transfer to out_vld when there is no backpressure.
  - Throughput is 1 result per cycle.
- Stall rules:
  - en1 = !s1_vld | out_rdy.
  - en0 = !s0_vld | en1.
  - in_rdy = en0; this is a combinational path from out_rdy, which is accepted.
- Stage 1 on en1:
  - It loads when s0_vld = 1.
  - Otherwise it clears s1_vld; data registers may hold.
- Stage 0 on en0:
  - It loads when in_vld = 1.
  - Otherwise it clears s0_vld.
- Holding stages:
  - A stalled stage holds its data and valid unchanged.
  - out_y and out_bout are stable while out_vld & !out_rdy.
- Full pipeline: both stages valid with out_rdy = 0 gives in_rdy = 0. Nothing is dropped or duplicated, and order is preserved.
- Simultaneous events: a transfer out and a transfer in on the same edge is legal; the pipeline shifts by one.
- Reset mid-operation: asserting rst_n low immediately clears both valids and the outputs. In-flight data is discarded, with no partial results after release.
- Wrap-around:
  - Underflow wraps modulo 2^W with out_bout = 1.
  - bin = 1 with a = b gives y = all-ones and bout = 1.
- Upstream rule: in_vld may be asserted without waiting for in_rdy. Data is only consumed on in_vld & in_rdy.

Decomposition:
- Package split_sub_pkg:
  - typedef w_t (W bits), lo_t (LO_W bits), hi_t (W-LO_W bits).
  - packed struct s0_t {lo_t diff; logic borrow; hi_t a_hi; hi_t b_hi;}.
  - packed struct result_t {logic bout; w_t y;}.
- Sub-module sub_slice: combinational N-bit subtractor with borrow-in and borrow-out, parameterised on N. It is instantiated twice, once per half.

Test Plan:
- Basic: W=32, in_a=5, in_b=3, in_bin=0 with out_rdy=1 -> out_vld=1 two cycles after transfer, out_y=0x0000_0002, out_bout=0.
- Underflow: in_a=0, in_b=1, in_bin=0 -> out_y=0xFFFF_FFFF, out_bout=1.
- Cross-half borrow: in_a=0x0001_0000, in_b=0x0000_0001, in_bin=0 -> out_y=0x0000_FFFF, out_bout=0. Plus in_a=0x8000_0000, in_b=0x8000_0000, in_bin=1 -> out_y=0xFFFF_FFFF, out_bout=1.
- Backpressure: stream of 4 back-to-back operands (a=10..13, b=1, bin=0) with out_rdy=0 for cycles 2-4:
  - in_rdy drops once both stages are full.
  - out_y holds stable while stalled.
  - Results 9, 10, 11, 12 appear in order, none lost or duplicated.
- Reset mid-flight: assert rst_n=0 with both stages valid -> out_vld, out_y, out_bout go to 0 without a clock edge. After release, in_rdy=1 and no stale result appears.
- Random: 10k random a, b, bin with random in_vld/out_rdy against the scoreboard model {bout, y} = {1'b0, a} - b - bin; zero mismatches.
